exc_entry_seq: RTL and testbench
================================

Name: exc_entry_seq

Overview:
- Exception-entry sequencer for the banked ARM register file.
- Takes pending exception requests from the core, masks and prioritises them, and switches the processor mode so the banked r13/r14 become visible.
- Writes the return address into the new mode's r14 through the file's write port, then redirects the PC to the vector.
- Stalls the pipeline (busy) for the whole sequence. Sits between the pipeline control and the register file/CPSR logic.

Parameters:
VEC_BASE, 32'h0000_0000, vector table base address; must be 32-byte aligned.
SVC_RESET_MODE, 5'b10011, mode presented on M while rst_n is low.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
exc_req  in  6  level requests: [0] und, [1] svc, [2] pabt, [3] irq, [4] fiq, [5] dabt; requester holds high until exc_ack.
exc_pc  in  32  address of the instruction associated with the exception.
cpsr_in  in  32  current CPSR; [4:0] mode, [7] I mask, [6] F mask.
M  out  5  mode driven to the register file.
write_reg  out  1  register-file write enable.
w_addr  out  4  register-file write address.
w_data  out  32  register-file write data.
write_pc  out  1  PC write enable.
pc_data  out  32  new PC.
spsr_we  out  1  one-cycle pulse: save cpsr_in into the SPSR of spsr_mode.
spsr_mode  out  5  target mode for the SPSR write.
spsr_data  out  32  CPSR value to save.
cpsr_we  out  1  one-cycle pulse: CPSR owner loads mode=M, plus the I/F set flags.
set_i  out  1  valid with cpsr_we: set I.
set_f  out  1  valid with cpsr_we: set F.
busy  out  1  sequence in progress; pipeline must stall.
exc_ack  out  1  one-cycle acknowledge of the serviced request.
exc_id  out  3  index (0-5) of the serviced request; valid with exc_ack.

Behaviour:
- State machine states: IDLE, SWITCH, WLR, WPC, DONE. Every output other than M is registered.
- Reset (async, rst_n=0):
  - state=IDLE.
  - All enables, pulses, busy and exc_ack = 0.
  - Data outputs = 0; exc_id = 0.
  - M = SVC_RESET_MODE.
- Masking: irq is eligible only if cpsr_in[7]=0; fiq only if cpsr_in[6]=0. All other requests are always eligible.
- Priority, highest first: dabt > fiq > irq > pabt > und > svc.
- IDLE:
  - M = cpsr_in[4:0] (pass-through).
  - On a rising edge with any eligible request: latch the winner id, exc_pc and cpsr_in; go to SWITCH; busy=1; spsr_we=1 for one cycle with spsr_mode=target and spsr_data=latched cpsr.
- Target modes: fiq 10001, irq 10010, svc 10011 (und? no, see next line), abt 10111.
  - fiq -> 10001; irq -> 10010; svc -> 10011; pabt/dabt -> 10111; und -> 11011.
- SWITCH: M = target mode (held from here through DONE, so the file selects the new bank). One cycle, then WLR.
- WLR: write_reg=1, w_addr=14, w_data = latched exc_pc + offset. One cycle, then WPC.
  - Offset is 8 for dabt, 4 for all others.
  - Addition is 32-bit and wraps modulo 2^32.
- WPC: write_pc=1, pc_data = VEC_BASE + vector. One cycle, then DONE.
  - Vectors: und 0x04, svc 0x08, pabt 0x0C, dabt 0x10, irq 0x18, fiq 0x1C.
- DONE:
  - exc_ack=1, exc_id=latched id.
  - cpsr_we=1; set_i=1 always; set_f=1 only for fiq.
  - Next edge: IDLE, busy=0.
- Latency: request seen at edge 0 -> LR write enabled during cycle 2 -> PC write in cycle 3 -> ack in cycle 4 -> idle at cycle 5.
- Write timing: outputs are stable for the whole cycle, so the register file's falling-edge writes capture them mid-cycle.
- Requests that change or arrive while busy are ignored until IDLE; the winner is re-evaluated there.
- A request dropped mid-sequence does not abort the sequence.
- rst_n asserted mid-sequence: immediate return to reset values. No partial write pulse may persist past the reset edge.
- write_reg and write_pc are never high in the same cycle.

Decomposition:
- Shared package exc_pkg holds:
  - mode encodings (USR/FIQ/IRQ/SVC/ABT/UND/SYS);
  - exception index constants;
  - vector offsets;
  - LR offset table;
  - state enum.
- One sub-module, exc_prio_enc: combinational masking plus fixed-priority encoder producing valid, id[2:0] and target mode.

Test Plan:
- Reset: rst_n=0 -> M=10011, busy=0, write_reg=0, write_pc=0. Release with cpsr_in[4:0]=10000 -> M=10000.
- IRQ entry: exc_req=6'b001000, cpsr_in=32'h10 (I=0), exc_pc=32'h100 -> in order:
  - spsr_we with spsr_data=32'h10;
  - M=10010;
  - write_reg with w_addr=14, w_data=32'h104;
  - write_pc with pc_data=32'h18;
  - exc_ack with exc_id=3, set_i=1, set_f=0.
- Priority/mask: exc_req=6'b111000, cpsr_in[6]=1 -> dabt wins, M=10111, w_data=exc_pc+8, pc_data=32'h10. Same stimulus with exc_req=6'b011000, cpsr_in[7:6]=2'b11 -> no entry, busy stays 0.
- Busy lockout: start svc entry, then raise fiq at cycle 2 -> svc sequence completes unchanged. Next edge in IDLE starts fiq entry: M=10001, pc_data=32'h1C, set_f=1.
- Reset mid-sequence: assert rst_n=0 during WLR -> write_reg drops immediately, busy=0, M=10011, no exc_ack.
- Wrap: VEC_BASE=32'hFFFF0000, exc_pc=32'hFFFFFFFC, und -> w_data=32'h00000000, pc_data=32'hFFFF0004, M=11011.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the exception-entry sequencer: ARM mode encodings,
// exception indices, vector/LR offset tables, output bundle and FSM state enum.
package exc_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam logic [2:0] EXC_UND  = 3'd0;
    localparam logic [2:0] EXC_SVC  = 3'd1;
    localparam logic [2:0] EXC_PABT = 3'd2;
    localparam logic [2:0] EXC_IRQ  = 3'd3;
    localparam logic [2:0] EXC_FIQ  = 3'd4;
    localparam logic [2:0] EXC_DABT = 3'd5;

    localparam logic [3:0] LR_ADDR = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWITCH = 3'd1,
        ST_WLR    = 3'd2,
        ST_WPC    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic        write_reg;
        logic [3:0]  w_addr;
        logic [31:0] w_data;
        logic        write_pc;
        logic [31:0] pc_data;
        logic        spsr_we;
        logic [4:0]  spsr_mode;
        logic [31:0] spsr_data;
        logic        cpsr_we;
        logic        set_i;
        logic        set_f;
        logic        busy;
        logic        exc_ack;
        logic [2:0]  exc_id;
    } seq_out_t;

    function automatic logic [31:0] vec_offset(input logic [2:0] id);
        case (id)
            EXC_UND:  return 32'h0000_0004;
            EXC_SVC:  return 32'h0000_0008;
            EXC_PABT: return 32'h0000_000C;
            EXC_DABT: return 32'h0000_0010;
            EXC_IRQ:  return 32'h0000_0018;
            EXC_FIQ:  return 32'h0000_001C;
            default:  return 32'h0000_0000;
        endcase
    endfunction

    // Data aborts are detected one stage later, so their return address is +8.
    function automatic logic [31:0] lr_offset(input logic [2:0] id);
        case (id)
            EXC_DABT: return 32'h0000_0008;
            default:  return 32'h0000_0004;
        endcase
    endfunction

    function automatic logic [4:0] target_mode(input logic [2:0] id);
        case (id)
            EXC_UND:  return MODE_UND;
            EXC_SVC:  return MODE_SVC;
            EXC_PABT: return MODE_ABT;
            EXC_DABT: return MODE_ABT;
            EXC_IRQ:  return MODE_IRQ;
            EXC_FIQ:  return MODE_FIQ;
            default:  return MODE_SVC;
        endcase
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Masks irq/fiq with the CPSR I/F bits and picks the highest-priority request:
// dabt > fiq > irq > pabt > und > svc.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [5:0] req,
    input  logic       mask_i,
    input  logic       mask_f,
    output logic       valid,
    output logic [2:0] id,
    output logic [4:0] mode
);

    logic [5:0] elig_s;

    // Apply the CPSR interrupt masks, then fixed-priority select.
    always_comb begin
        elig_s           = req;
        elig_s[EXC_IRQ]  = req[EXC_IRQ] & ~mask_i;
        elig_s[EXC_FIQ]  = req[EXC_FIQ] & ~mask_f;
        valid            = 1'b1;
        if (elig_s[EXC_DABT]) begin
            id = EXC_DABT;
        end else if (elig_s[EXC_FIQ]) begin
            id = EXC_FIQ;
        end else if (elig_s[EXC_IRQ]) begin
            id = EXC_IRQ;
        end else if (elig_s[EXC_PABT]) begin
            id = EXC_PABT;
        end else if (elig_s[EXC_UND]) begin
            id = EXC_UND;
        end else if (elig_s[EXC_SVC]) begin
            id = EXC_SVC;
        end else begin
            valid = 1'b0;
            id    = EXC_UND;
        end
        mode = target_mode(id);
    end

endmodule

// File: rtl/exc_entry_seq.sv
// Exception-entry sequencer: saves CPSR to SPSR, switches mode, writes the
// return address to banked r14, redirects the PC, then acknowledges.
module exc_entry_seq
    import exc_pkg::*;
#(
    parameter logic [31:0] VEC_BASE       = 32'h0000_0000,
    parameter logic [4:0]  SVC_RESET_MODE = 5'b10011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  exc_req,
    input  logic [31:0] exc_pc,
    input  logic [31:0] cpsr_in,
    output logic [4:0]  M,
    output logic        write_reg,
    output logic [3:0]  w_addr,
    output logic [31:0] w_data,
    output logic        write_pc,
    output logic [31:0] pc_data,
    output logic        spsr_we,
    output logic [4:0]  spsr_mode,
    output logic [31:0] spsr_data,
    output logic        cpsr_we,
    output logic        set_i,
    output logic        set_f,
    output logic        busy,
    output logic        exc_ack,
    output logic [2:0]  exc_id
);

    state_e      state_r, next_state_s;
    logic        enc_valid_s;
    logic [2:0]  enc_id_s;
    logic [4:0]  enc_mode_s;
    logic [2:0]  id_r;
    logic [31:0] pc_r;
    logic [4:0]  mode_r;
    seq_out_t    out_s, out_r;

    exc_prio_enc u_prio (
        .req    (exc_req),
        .mask_i (cpsr_in[7]),
        .mask_f (cpsr_in[6]),
        .valid  (enc_valid_s),
        .id     (enc_id_s),
        .mode   (enc_mode_s)
    );

    // State register and capture of the winning request when leaving IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            id_r    <= 3'd0;
            pc_r    <= 32'h0000_0000;
            mode_r  <= SVC_RESET_MODE;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_IDLE && enc_valid_s) begin
                id_r   <= enc_id_s;
                pc_r   <= exc_pc;
                mode_r <= enc_mode_s;
            end
        end
    end

    // Next-state logic; requests are only examined in IDLE.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (enc_valid_s) begin
                    next_state_s = ST_SWITCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SWITCH: next_state_s = ST_WLR;
            ST_WLR:    next_state_s = ST_WPC;
            ST_WPC:    next_state_s = ST_DONE;
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so registered outputs line up with it.
    always_comb begin
        out_s = '0;
        case (next_state_s)
            ST_SWITCH: begin
                out_s.busy      = 1'b1;
                out_s.spsr_we   = 1'b1;
                out_s.spsr_mode = enc_mode_s;
                out_s.spsr_data = cpsr_in;
            end
            ST_WLR: begin
                out_s.busy      = 1'b1;
                out_s.write_reg = 1'b1;
                out_s.w_addr    = LR_ADDR;
                out_s.w_data    = pc_r + lr_offset(id_r);
            end
            ST_WPC: begin
                out_s.busy     = 1'b1;
                out_s.write_pc = 1'b1;
                out_s.pc_data  = VEC_BASE + vec_offset(id_r);
            end
            ST_DONE: begin
                out_s.busy    = 1'b1;
                out_s.exc_ack = 1'b1;
                out_s.exc_id  = id_r;
                out_s.cpsr_we = 1'b1;
                out_s.set_i   = 1'b1;
                out_s.set_f   = (id_r == EXC_FIQ);
            end
            default: out_s = '0;
        endcase
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
        end else begin
            out_r <= out_s;
        end
    end

    // Mode is combinational: CPSR pass-through in IDLE, the new bank while sequencing.
    always_comb begin
        if (!rst_n) begin
            M = SVC_RESET_MODE;
        end else if (state_r == ST_IDLE) begin
            M = cpsr_in[4:0];
        end else begin
            M = mode_r;
        end
    end

    assign write_reg = out_r.write_reg;
    assign w_addr    = out_r.w_addr;
    assign w_data    = out_r.w_data;
    assign write_pc  = out_r.write_pc;
    assign pc_data   = out_r.pc_data;
    assign spsr_we   = out_r.spsr_we;
    assign spsr_mode = out_r.spsr_mode;
    assign spsr_data = out_r.spsr_data;
    assign cpsr_we   = out_r.cpsr_we;
    assign set_i     = out_r.set_i;
    assign set_f     = out_r.set_f;
    assign busy      = out_r.busy;
    assign exc_ack   = out_r.exc_ack;
    assign exc_id    = out_r.exc_id;

endmodule

// File: tb/tb_exc_entry_seq.sv
// Bench for exc_entry_seq: a cycle-timeline model checked every negedge, plus
// directed vectors with literal expectations. Two instances cover VEC_BASE.
module tb_exc_entry_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  exc_req = 6'd0;
    logic [31:0] exc_pc = 32'h0;
    logic [31:0] cpsr_in = 32'h10;

    logic [4:0]  M, spsr_mode, M_b, spsr_mode_b;
    logic        write_reg, write_pc, spsr_we, cpsr_we, set_i, set_f, busy, exc_ack;
    logic        write_reg_b, write_pc_b, spsr_we_b, cpsr_we_b, set_i_b, set_f_b, busy_b, exc_ack_b;
    logic [3:0]  w_addr, w_addr_b;
    logic [31:0] w_data, pc_data, spsr_data, w_data_b, pc_data_b, spsr_data_b;
    logic [2:0]  exc_id, exc_id_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exc_entry_seq dut (
        .clk(clk), .rst_n(rst_n), .exc_req(exc_req), .exc_pc(exc_pc), .cpsr_in(cpsr_in),
        .M(M), .write_reg(write_reg), .w_addr(w_addr), .w_data(w_data),
        .write_pc(write_pc), .pc_data(pc_data), .spsr_we(spsr_we), .spsr_mode(spsr_mode),
        .spsr_data(spsr_data), .cpsr_we(cpsr_we), .set_i(set_i), .set_f(set_f),
        .busy(busy), .exc_ack(exc_ack), .exc_id(exc_id)
    );

    exc_entry_seq #(.VEC_BASE(32'hFFFF_0000)) dut_b (
        .clk(clk), .rst_n(rst_n), .exc_req(exc_req), .exc_pc(exc_pc), .cpsr_in(cpsr_in),
        .M(M_b), .write_reg(write_reg_b), .w_addr(w_addr_b), .w_data(w_data_b),
        .write_pc(write_pc_b), .pc_data(pc_data_b), .spsr_we(spsr_we_b), .spsr_mode(spsr_mode_b),
        .spsr_data(spsr_data_b), .cpsr_we(cpsr_we_b), .set_i(set_i_b), .set_f(set_f_b),
        .busy(busy_b), .exc_ack(exc_ack_b), .exc_id(exc_id_b)
    );

    // Reference tables indexed by exception id (und, svc, pabt, irq, fiq, dabt).
    logic [4:0]  mode_tab [6] = '{5'b11011, 5'b10011, 5'b10111, 5'b10010, 5'b10001, 5'b10111};
    logic [31:0] vec_tab  [6] = '{32'h04, 32'h08, 32'h0C, 32'h18, 32'h1C, 32'h10};
    int          prio     [6] = '{5, 4, 3, 2, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [5:0] r, input logic [31:0] c);
        for (int k = 0; k < 6; k++) begin
            int e;
            e = prio[k];
            if (r[e] && !(e == 3 && c[7]) && !(e == 4 && c[6])) return e;
        end
        return -1;
    endfunction

    // Model: phase 0 is idle, phases 1..4 are the four cycles of an entry.
    int          m_phase = 0;
    int          m_id = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_cpsr = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (pick(exc_req, cpsr_in) >= 0) begin
                m_phase <= 1;
                m_id    <= pick(exc_req, cpsr_in);
                m_pc    <= exc_pc;
                m_cpsr  <= cpsr_in;
            end
        end else begin
            m_phase <= (m_phase == 4) ? 0 : m_phase + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("r_M", 32'(M), 32'h13);
            chk("r_busy", 32'(busy), 32'h0);
            chk("r_write_reg", 32'(write_reg), 32'h0);
            chk("r_write_pc", 32'(write_pc), 32'h0);
            chk("r_spsr_we", 32'(spsr_we), 32'h0);
            chk("r_cpsr_we", 32'(cpsr_we), 32'h0);
            chk("r_exc_ack", 32'(exc_ack), 32'h0);
            chk("r_exc_id", 32'(exc_id), 32'h0);
            chk("r_w_data", w_data, 32'h0);
            chk("r_pc_data", pc_data, 32'h0);
        end else begin
            chk("m_M", 32'(M), (m_phase == 0) ? 32'(cpsr_in[4:0]) : 32'(mode_tab[m_id]));
            chk("m_busy", 32'(busy), 32'(m_phase != 0));
            chk("m_spsr_we", 32'(spsr_we), 32'(m_phase == 1));
            chk("m_write_reg", 32'(write_reg), 32'(m_phase == 2));
            chk("m_write_pc", 32'(write_pc), 32'(m_phase == 3));
            chk("m_exc_ack", 32'(exc_ack), 32'(m_phase == 4));
            chk("m_cpsr_we", 32'(cpsr_we), 32'(m_phase == 4));
            if (m_phase == 1) begin
                chk("m_spsr_mode", 32'(spsr_mode), 32'(mode_tab[m_id]));
                chk("m_spsr_data", spsr_data, m_cpsr);
            end
            if (m_phase == 2) begin
                chk("m_w_addr", 32'(w_addr), 32'd14);
                chk("m_w_data", w_data, m_pc + ((m_id == 5) ? 32'd8 : 32'd4));
                chk("m_w_data_b", w_data_b, m_pc + ((m_id == 5) ? 32'd8 : 32'd4));
            end
            if (m_phase == 3) begin
                chk("m_pc_data", pc_data, vec_tab[m_id]);
                chk("m_pc_data_b", pc_data_b, 32'hFFFF_0000 + vec_tab[m_id]);
            end
            if (m_phase == 4) begin
                chk("m_exc_id", 32'(exc_id), 32'(m_id));
                chk("m_set_i", 32'(set_i), 32'h1);
                chk("m_set_f", 32'(set_f), 32'(m_id == 4));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(); step();
        chk("rst_M", 32'(M), 32'h13);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_write_reg", 32'(write_reg), 32'h0);
        chk("rst_write_pc", 32'(write_pc), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_M", 32'(M), 32'h10);
        step();

        // IRQ entry with I clear.
        exc_req = 6'b001000; exc_pc = 32'h100;
        step(); chk("irq_spsr_we", 32'(spsr_we), 32'h1); chk("irq_spsr_data", spsr_data, 32'h10);
        chk("irq_M", 32'(M), 32'h12);
        step(); chk("irq_wr", 32'(write_reg), 32'h1); chk("irq_waddr", 32'(w_addr), 32'hE);
        chk("irq_wdata", w_data, 32'h104);
        step(); chk("irq_wpc", 32'(write_pc), 32'h1); chk("irq_pc", pc_data, 32'h18);
        step(); chk("irq_ack", 32'(exc_ack), 32'h1); chk("irq_id", 32'(exc_id), 32'h3);
        chk("irq_set_i", 32'(set_i), 32'h1); chk("irq_set_f", 32'(set_f), 32'h0);
        exc_req = 6'b0;
        step(); chk("irq_idle", 32'(busy), 32'h0);

        // dabt beats fiq (masked) and irq.
        cpsr_in = 32'h50; exc_req = 6'b111000; exc_pc = 32'h200;
        step(); chk("dabt_M", 32'(M), 32'h17);
        step(); chk("dabt_wdata", w_data, 32'h208);
        step(); chk("dabt_pc", pc_data, 32'h10);
        step(); chk("dabt_id", 32'(exc_id), 32'h5);
        exc_req = 6'b0;
        step();

        // Both irq and fiq masked: no entry.
        cpsr_in = 32'hD0; exc_req = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            step(); chk("mask_busy", 32'(busy), 32'h0);
        end
        exc_req = 6'b0;

        // svc in flight, fiq raised mid-sequence is held off until IDLE.
        cpsr_in = 32'h10; exc_req = 6'b000010; exc_pc = 32'h300;
        step(); step();
        exc_req = 6'b010010;
        step(); chk("svc_pc", pc_data, 32'h8);
        step(); chk("svc_id", 32'(exc_id), 32'h1); chk("svc_set_f", 32'(set_f), 32'h0);
        exc_req = 6'b010000;
        step(); chk("gap_busy", 32'(busy), 32'h0);
        step(); chk("fiq_M", 32'(M), 32'h11); chk("fiq_spsr_mode", 32'(spsr_mode), 32'h11);
        step(); step(); chk("fiq_pc", pc_data, 32'h1C);
        step(); chk("fiq_id", 32'(exc_id), 32'h4); chk("fiq_set_f", 32'(set_f), 32'h1);
        exc_req = 6'b0;
        step();

        // und with wrapping return address and high vector base.
        exc_req = 6'b000001; exc_pc = 32'hFFFF_FFFC;
        step(); chk("und_M", 32'(M), 32'h1B);
        step(); chk("und_wdata", w_data, 32'h0); chk("und_wdata_b", w_data_b, 32'h0);
        step(); chk("und_pc", pc_data, 32'h4); chk("und_pc_b", pc_data_b, 32'hFFFF_0004);
        step(); chk("und_id", 32'(exc_id), 32'h0);
        exc_req = 6'b0;
        step();

        // Reset asserted during the LR write.
        exc_req = 6'b000001; exc_pc = 32'h400;
        step(); step();
        chk("mid_wr_before", 32'(write_reg), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_wr", 32'(write_reg), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_M", 32'(M), 32'h13);
        exc_req = 6'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("mid_ack", 32'(exc_ack), 32'h0);
        end
        rst_n = 1'b1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
